// File: rtl/oscil_seq_ctrl_pkg.sv
// Shared definitions for the two-phase oscillator sequencer: FSM state
// encodings and the default counter width.
package oscil_seq_ctrl_pkg;

  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/oscil_seq_ctrl_div_ch.sv
// One oscillator channel: divisor register, half-period counter and toggle flop,
// advancing while running, or while stopping only until its output is low.
module oscil_div_ch
  import oscil_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             restart,
  input  logic             run,
  input  logic             stopping,
  output logic             f,
  output logic             frozen,
  output logic             rise
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             adv;

  always_comb begin
    term   = (cnt == (div - ONE));
    adv    = run | (stopping & f);
    rise   = adv & term & ~f;
    // At rest after this edge: already low, or a high output taking its falling toggle now.
    frozen = ~f | term;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div <= DEF_DIV_V;
      cnt <= '0;
      f   <= 1'b0;
    end else begin
      if (load) begin
        div <= (div_in == '0) ? ONE : div_in;
      end
      if (restart) begin
        cnt <= '0;
        f   <= 1'b0;
      end else if (adv) begin
        if (term) begin
          cnt <= '0;
          f   <= ~f;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/oscil_seq_ctrl.sv
// Run/stop sequencer for the two-phase oscillator outputs F0/F1: FSM, divisor
// configuration handshake (idle only) and coincident-rise SYNC detect.
module oscil_seq_ctrl
  import oscil_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEF_DIV0 = 2,
  parameter int unsigned DEF_DIV1 = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CNT_W-1:0] CFG_DIV0,
  input  logic [CNT_W-1:0] CFG_DIV1,
  input  logic             START,
  input  logic             STOP,
  output logic             F0,
  output logic             F1,
  output logic             BUSY,
  output logic             SYNC
);

  state_t state;
  logic   cfg_ready_q;
  logic   busy_q;
  logic   sync_q;

  logic   cfg_hs;
  logic   start_go;
  logic   in_run;
  logic   in_stopping;
  logic   f0, f1;
  logic   frozen0, frozen1;
  logic   rise0, rise1;

  always_comb begin
    cfg_hs      = CFG_VALID & cfg_ready_q;
    start_go    = (state == ST_IDLE) & START & ~STOP;
    in_run      = (state == ST_RUN);
    in_stopping = (state == ST_STOPPING);
  end

  oscil_div_ch #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV0)
  ) u_ch0 (
    .clk      (CLK),
    .clr      (CLR),
    .load     (cfg_hs),
    .div_in   (CFG_DIV0),
    .restart  (start_go),
    .run      (in_run),
    .stopping (in_stopping),
    .f        (f0),
    .frozen   (frozen0),
    .rise     (rise0)
  );

  oscil_div_ch #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV1)
  ) u_ch1 (
    .clk      (CLK),
    .clr      (CLR),
    .load     (cfg_hs),
    .div_in   (CFG_DIV1),
    .restart  (start_go),
    .run      (in_run),
    .stopping (in_stopping),
    .f        (f1),
    .frozen   (frozen1),
    .rise     (rise1)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state       <= ST_IDLE;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_q <= in_run & rise0 & rise1;
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state       <= ST_RUN;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (STOP) begin
            state <= ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          if (frozen0 & frozen1) begin
            state       <= ST_IDLE;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign F0        = f0;
  assign F1        = f1;
  assign BUSY      = busy_q;
  assign CFG_READY = cfg_ready_q;
  assign SYNC      = sync_q;

endmodule
